// File: rtl/rvc_compressor.sv
// rvc_compressor: streaming RV32I -> RVC re-encoder with halfword packer.
//
// Each accepted 32-bit instruction is either re-encoded as a 16-bit RVC
// parcel (when one of the supported compression rules matches) or passed
// through as two halfwords. Parcels are packed little-endian into 32-bit
// output words through a three-halfword buffer. A flush pulse drains the
// buffer and pads a lone trailing halfword with NOP_PARCEL.
//
// Build option: define RVC_COMPRESS_EN to enable the compression rules.
// Without it the encoder is bypassed and every instruction is buffered as
// two halfwords; packing and flush behave identically.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake, in_instr = RV32I instruction
//   flush              one-cycle pulse: drain buffer, pad final word
//   out_valid/out_ready output handshake, out_word = two parcels,
//                      older halfword in [15:0]
//   out_last           marks the word that empties the buffer on a flush
//   idle               buffer empty and no flush pending
module rvc_compressor #(
    parameter logic [15:0] NOP_PARCEL = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic        idle
);

    // Returns {compressed, data}. When compressed, data[15:0] holds the
    // RVC parcel and data[31:16] is zero; otherwise data is the original.
    function automatic logic [32:0] encode(input logic [31:0] ins);
        logic [32:0] r;
`ifdef RVC_COMPRESS_EN
        logic [6:0]         opc;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic signed [11:0] imm_i;
        logic signed [11:0] imm_s;
        logic signed [20:0] imm_j;
        logic               imm6;
        logic               lw_off;
        logic               sw_off;
        logic               j_off;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        rd    = ins[11:7];
        rs1   = ins[19:15];
        rs2   = ins[24:20];
        imm_i = ins[31:20];
        imm_s = {ins[31:25], ins[11:7]};
        imm_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm6   = (imm_i >= -12'sd32) && (imm_i <= 12'sd31);
        // word-aligned, 0..124: no bits above [6], none below [2]
        lw_off = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
        sw_off = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);
        j_off  = (imm_j >= -21'sd2048) && (imm_j <= 21'sd2046);
        r = {1'b0, ins};
        if (opc == 7'b0010011 && f3 == 3'b000 && rd == rs1 && rd != 5'd0
            && imm6 && imm_i != 12'sd0)
            r = {1'b1, 16'h0, 3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        else if (opc == 7'b0010011 && f3 == 3'b000 && rs1 == 5'd0
                 && rd != 5'd0 && imm6)
            r = {1'b1, 16'h0, 3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        else if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'd0
                 && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0)
            r = {1'b1, 16'h0, 4'b1000, rd, rs2, 2'b10};
        else if (opc == 7'b0110011 && f3 == 3'b000 && f7 == 7'd0
                 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
            r = {1'b1, 16'h0, 4'b1001, rd, rs2, 2'b10};
        else if (opc == 7'b0000011 && f3 == 3'b010 && rd[4:3] == 2'b01
                 && rs1[4:3] == 2'b01 && lw_off)
            r = {1'b1, 16'h0, 3'b010, imm_i[5:3], rs1[2:0], imm_i[2],
                 imm_i[6], rd[2:0], 2'b00};
        else if (opc == 7'b0100011 && f3 == 3'b010 && rs2[4:3] == 2'b01
                 && rs1[4:3] == 2'b01 && sw_off)
            r = {1'b1, 16'h0, 3'b110, imm_s[5:3], rs1[2:0], imm_s[2],
                 imm_s[6], rs2[2:0], 2'b00};
        else if (opc == 7'b1101111 && rd == 5'd0 && j_off)
            r = {1'b1, 16'h0, 3'b101, imm_j[11], imm_j[4], imm_j[9:8],
                 imm_j[10], imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
`else
        r = {1'b0, ins};
`endif
        return r;
    endfunction

    logic [47:0] hbuf, hbuf_n, shifted;
    logic [1:0]  count, count_n, n_emit, n_add, base;
    logic        flush_pending, fp_n;
    logic [32:0] enc;
    logic        accept, emit;

    always_comb begin
        enc       = encode(in_instr);
        out_valid = (count >= 2'd2) || (flush_pending && count == 2'd1);
        out_word  = (count == 2'd1) ? {NOP_PARCEL, hbuf[15:0]} : hbuf[31:0];
        out_last  = flush_pending && (count == 2'd1 || count == 2'd2);
        in_ready  = !flush_pending && (count <= 2'd1 || out_ready);
        idle      = (count == 2'd0) && !flush_pending;
        accept    = in_valid && in_ready;
        emit      = out_valid && out_ready;

        // a padded word consumes only the single real halfword
        n_emit = 2'd0;
        if (emit)
            n_emit = (count == 2'd1) ? 2'd1 : 2'd2;
        case (n_emit)
            2'd1:    shifted = {16'h0, hbuf[47:16]};
            2'd2:    shifted = {32'h0, hbuf[47:32]};
            default: shifted = hbuf;
        endcase

        // in_ready guarantees at most one halfword survives when accepting,
        // so the new parcel lands at slot 0 or 1; a 32-bit one at slot 1
        // straddles into the next word.
        base   = count - n_emit;
        hbuf_n = shifted;
        n_add  = 2'd0;
        if (accept) begin
            n_add = enc[32] ? 2'd1 : 2'd2;
            if (base == 2'd0)
                hbuf_n[31:0] = enc[31:0];
            else
                hbuf_n[47:16] = enc[31:0];
        end
        count_n = base + n_add;

        // pending flush retires as soon as the buffer runs empty
        fp_n = flush_pending ? (count_n != 2'd0) : flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= 2'd0;
            flush_pending <= 1'b0;
            hbuf          <= 48'h0;
        end else begin
            count         <= count_n;
            flush_pending <= fp_n;
            hbuf          <= hbuf_n;
        end
    end

endmodule

// File: tb/tb_rvc_compressor.sv
module tb_rvc_compressor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic        out_last;
    logic        idle;

    int errors = 0;
    int checks = 0;

    rvc_compressor dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_word(out_word), .out_last(out_last),
        .idle(idle)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] mq[$];
    bit          mfp = 1'b0;

    function automatic bit m_compress(input logic [31:0] ins, output logic [15:0] p);
        int opc, f3, f7, rd, rs1, rs2, ii, si, jo;
        p = 16'h0;
        opc = int'(ins[6:0]);   f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
        rd  = int'(ins[11:7]);  rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]);
        ii = int'(ins[31:20]);  if (ii >= 2048) ii -= 4096;
        si = int'({ins[31:25], ins[11:7]}); if (si >= 2048) si -= 4096;
        jo = int'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
        if (jo >= 1048576) jo -= 2097152;
`ifdef RVC_COMPRESS_EN
        if (opc == 19 && f3 == 0 && rd == rs1 && rd != 0 && ii >= -32 && ii <= 31 && ii != 0) begin
            p = 16'((((ii >> 5) & 1) << 12) | (rd << 7) | ((ii & 31) << 2) | 1);
            return 1'b1;
        end
        if (opc == 19 && f3 == 0 && rs1 == 0 && rd != 0 && ii >= -32 && ii <= 31) begin
            p = 16'((2 << 13) | (((ii >> 5) & 1) << 12) | (rd << 7) | ((ii & 31) << 2) | 1);
            return 1'b1;
        end
        if (opc == 51 && f3 == 0 && f7 == 0 && rd != 0 && rs1 == 0 && rs2 != 0) begin
            p = 16'((8 << 12) | (rd << 7) | (rs2 << 2) | 2);
            return 1'b1;
        end
        if (opc == 51 && f3 == 0 && f7 == 0 && rd == rs1 && rd != 0 && rs2 != 0) begin
            p = 16'((9 << 12) | (rd << 7) | (rs2 << 2) | 2);
            return 1'b1;
        end
        if (opc == 3 && f3 == 2 && rd >= 8 && rd <= 15 && rs1 >= 8 && rs1 <= 15
            && ii >= 0 && ii <= 124 && (ii % 4) == 0) begin
            p = 16'((2 << 13) | (((ii >> 3) & 7) << 10) | ((rs1 - 8) << 7)
                    | (((ii >> 2) & 1) << 6) | (((ii >> 6) & 1) << 5) | ((rd - 8) << 2));
            return 1'b1;
        end
        if (opc == 35 && f3 == 2 && rs2 >= 8 && rs2 <= 15 && rs1 >= 8 && rs1 <= 15
            && si >= 0 && si <= 124 && (si % 4) == 0) begin
            p = 16'((6 << 13) | (((si >> 3) & 7) << 10) | ((rs1 - 8) << 7)
                    | (((si >> 2) & 1) << 6) | (((si >> 6) & 1) << 5) | ((rs2 - 8) << 2));
            return 1'b1;
        end
        if (opc == 111 && rd == 0 && jo >= -2048 && jo <= 2046) begin
            p = 16'((5 << 13) | (((jo >> 11) & 1) << 12) | (((jo >> 4) & 1) << 11)
                    | (((jo >> 8) & 3) << 9) | (((jo >> 10) & 1) << 8) | (((jo >> 6) & 1) << 7)
                    | (((jo >> 7) & 1) << 6) | (((jo >> 1) & 7) << 3) | (((jo >> 5) & 1) << 2) | 1);
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    function automatic void m_push(input logic [31:0] ins);
        logic [15:0] p;
        if (m_compress(ins, p)) mq.push_back(p);
        else begin
            mq.push_back(ins[15:0]);
            mq.push_back(ins[31:16]);
        end
    endfunction

    function automatic bit m_valid();
        return mq.size() >= 2 || (mfp && mq.size() == 1);
    endfunction
    function automatic bit m_ready();
        return !mfp && (mq.size() <= 1 || out_ready);
    endfunction
    function automatic bit m_last();
        return mfp && (mq.size() == 1 || mq.size() == 2);
    endfunction
    function automatic bit m_idle();
        return !mfp && mq.size() == 0;
    endfunction
    function automatic logic [31:0] m_word();
        if (mq.size() >= 2) return {mq[1], mq[0]};
        if (mq.size() == 1) return {16'h0001, mq[0]};
        return 32'h0;
    endfunction

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic tick();
        bit acc, emt;
        logic [31:0] ii;
        bit fl;
        acc = in_valid && m_ready();
        emt = m_valid() && out_ready;
        ii  = in_instr;
        fl  = flush;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mfp = 1'b0;
        end else begin
            if (emt) begin
                if (mq.size() >= 2) begin
                    void'(mq.pop_front());
                    void'(mq.pop_front());
                end else void'(mq.pop_front());
            end
            if (acc) m_push(ii);
            if (mfp) mfp = (mq.size() != 0);
            else     mfp = fl;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        int k;
        logic [4:0] rd, rs1, rs2;
        logic [11:0] imm, off;
        logic [20:0] jo;
        logic [31:0] r;
        k   = int'($urandom_range(0, 9));
        rd  = 5'($urandom_range(0, 15));
        rs1 = ($urandom_range(0, 2) == 0) ? 5'd0 :
              (($urandom_range(0, 1) == 0) ? rd : 5'($urandom_range(0, 31)));
        rs2 = 5'($urandom_range(0, 15));
        imm = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 80)) - 12'd40 : 12'($urandom);
        off = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 40) * 4) : imm;
        jo  = 21'(int'($urandom_range(0, 4400)) - 2200);
        jo[0] = 1'b0;
        case (k)
            0, 1: r = {imm, rs1, 3'b000, rd, 7'h13};
            2, 3: r = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            4: r = {off, 5'($urandom_range(6, 17)), 3'b010, 5'($urandom_range(6, 17)), 7'h03};
            5: r = {off[11:5], 5'($urandom_range(6, 17)), 5'($urandom_range(6, 17)), 3'b010, off[4:0], 7'h23};
            6: r = {jo[20], jo[10:1], jo[11], jo[19:12], ($urandom_range(0, 2) == 0) ? rd : 5'd0, 7'h6f};
            default: r = $urandom;
        endcase
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", idle); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL reset_out_word got=%h exp=00000000", out_word); end
    endtask

`ifdef RVC_COMPRESS_EN
    task automatic test_compress_pair();
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00550513;
        #1; tick();
        in_instr = 32'h00442483;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pair_half_valid got=%b exp=0", out_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h40440515)
            begin errors++; $display("FAIL pair_word got=%b/%h exp=1/40440515", out_valid, out_word); end
        tick();
        #1;
        checks++; if (idle !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL pair_empty idle=%b valid=%b exp=1/0", idle, out_valid); end
    endtask

    task automatic test_straddle_flush();
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00550513;
        #1; tick();
        in_instr = 32'h003100B3;
        #1; tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h00B30515)
            begin errors++; $display("FAIL straddle_word got=%b/%h exp=1/00b30515", out_valid, out_word); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b0 || idle !== 1'b0) begin errors++; $display("FAIL straddle_hold valid=%b idle=%b exp=0/0", out_valid, idle); end
        flush = 1'b1;
        #1; tick();
        flush = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h00010031 || out_last !== 1'b1)
            begin errors++; $display("FAIL flush_pad got=%b/%h/%b exp=1/00010031/1", out_valid, out_word, out_last); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_block in_ready=%b exp=0", in_ready); end
        tick();
        #1;
        checks++; if (idle !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle idle=%b valid=%b exp=1/0", idle, out_valid); end
    endtask
`else
    task automatic test_bypass();
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00550513;
        #1; tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h00550513)
            begin errors++; $display("FAIL bypass_word got=%b/%h exp=1/00550513", out_valid, out_word); end
        tick();
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL bypass_idle got=%b exp=1", idle); end
    endtask
`endif

    task automatic test_back_to_back();
        apply_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000013;
        #1; tick();
        in_instr = 32'h08042483;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h00000013)
            begin errors++; $display("FAIL b2b_word0 got=%b/%h exp=1/00000013", out_valid, out_word); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h08042483)
            begin errors++; $display("FAIL b2b_word1 got=%b/%h exp=1/08042483", out_valid, out_word); end
        tick();
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", idle); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0;
        logic [31:0] seq [2];
        seq[0] = 32'h00550513;
        seq[1] = 32'h003100B3;
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_instr = seq[k];
            #1;
            if (!m_ready()) break;
            tick();
        end
        in_valid = 1'b1; in_instr = 32'h00550513;
        #1;
        w0 = out_word;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
`ifdef RVC_COMPRESS_EN
        checks++; if (out_word !== 32'h00B30515) begin errors++; $display("FAIL bp_word got=%h exp=00b30515", out_word); end
`else
        checks++; if (out_word !== 32'h00550513) begin errors++; $display("FAIL bp_word got=%h exp=00550513", out_word); end
`endif
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            checks++; if (out_word !== w0 || out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_stable got=%b/%h exp=1/%h", out_valid, out_word, w0); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready=%b exp=1", in_ready); end
        tick();
    endtask

    task automatic test_reset_midop();
        apply_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00550513;
        #1; tick();
        in_instr = 32'h003100B3;
        #1; if (m_ready()) tick();
        in_valid = 1'b0; flush = 1'b1;
        #1; tick();
        flush = 1'b0;
        #1;
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL midop_busy idle=%b exp=0", idle); end
        apply_reset();
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || idle !== 1'b1 || in_ready !== 1'b1 || out_word !== 32'h0)
            begin errors++; $display("FAIL midop_reset valid=%b idle=%b rdy=%b word=%h exp=0/1/1/00000000", out_valid, idle, in_ready, out_word); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL midop_noword valid=%b idle=%b exp=0/1", out_valid, idle); end
    endtask

    task automatic test_random();
        int guard;
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = gen_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            checks++; if (out_valid !== m_valid()) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, out_valid, m_valid()); end
            checks++; if (in_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, in_ready, m_ready()); end
            checks++; if (idle !== m_idle()) begin errors++; $display("FAIL rnd_idle n=%0d got=%b exp=%b", n, idle, m_idle()); end
            checks++; if (out_last !== m_last()) begin errors++; $display("FAIL rnd_last n=%0d got=%b exp=%b", n, out_last, m_last()); end
            if (m_valid()) begin
                checks++; if (out_word !== m_word()) begin errors++; $display("FAIL rnd_word n=%0d got=%h exp=%h", n, out_word, m_word()); end
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        #1; tick();
        flush = 1'b0;
        guard = 0;
        while (!m_idle() && guard < 20) begin
            #1;
            if (m_valid()) begin
                checks++; if (out_word !== m_word() || out_last !== m_last())
                    begin errors++; $display("FAIL drain_word got=%h/%b exp=%h/%b", out_word, out_last, m_word(), m_last()); end
            end
            tick();
            guard++;
        end
        #1;
        checks++; if (guard >= 20 || idle !== 1'b1) begin errors++; $display("FAIL drain_idle got=%b exp=1 cycles=%0d", idle, guard); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
`ifdef RVC_COMPRESS_EN
        test_compress_pair();
        test_straddle_flush();
`else
        test_bypass();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
